sb_spi_host: RTL and testbench
==============================

Name: sb_spi_host

Overview:
- System-bus initiator that drives the iCE40 SB_SPI hard block's register interface (SBSTBI/SBRWI/SBADRI/SBDATI in, SBDATO/SBACKO back) as an SPI master.
- Converts a byte stream into SPI frames:
  - configures SB_SPI once after reset;
  - per byte: polls status, writes TX, polls status, reads RX;
  - brackets each frame with chip-select writes.
- Sits between the motion/command logic and the SB_SPI instance; in simulation it faces the DPI-backed SB_SPI model.

Parameters:
- BUS_ADDR74, 4'b0000, upper address nibble of the target SB_SPI; must match the instance's BUS_ADDR74.
- CR0_VAL, 8'h00, value written to SPICR0 (offset 0x8).
- CR1_VAL, 8'h80, value written to SPICR1 (offset 0x9); bit7 SPE enables the core.
- CR2_VAL, 8'hC0, value written to SPICR2 (offset 0xA); MSTR and MCSH set.
- BR_VAL, 8'h05, value written to SPIBR (offset 0xB).
- CS_MASK, 8'h01, SPICSR (offset 0xF) value at frame start; 8'h00 is written at frame end.
- ACK_TIMEOUT, 64, bus-ack watchdog limit in cycles (only with the optional feature).

Ports:
- clk  in  1  system clock; also drives SB_SPI SBCLKI.
- rst_n  in  1  synchronous active-low reset.
- tx_data  in  8  byte to shift out.
- tx_last  in  1  byte ends the frame.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_ready  out  1  byte accepted when tx_valid && tx_ready.
- rx_data  out  8  byte shifted in.
- rx_valid  out  1  rx_data valid; held until accepted.
- rx_ready  in  1  consumer ready.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky bus-timeout flag.
- sb_stb  out  1  to SBSTBI.
- sb_rw  out  1  to SBRWI; 1 = write.
- sb_adr  out  8  to SBADRI7..0.
- sb_dat_w  out  8  to SBDATI7..0.
- sb_dat_r  in  8  from SBDATO7..0.
- sb_ack  in  1  from SBACKO.

Behaviour:
- Reset values:
  - sb_stb=0, sb_rw=0, sb_adr=0, sb_dat_w=0.
  - tx_ready=0, rx_valid=0, rx_data=0.
  - busy=1, err=0.
  - State = CFG0.
  - Reset mid-transaction drops sb_stb the next edge and restarts configuration.
- Bus cycle (shared by every state that touches SB_SPI):
  - sb_stb rises one cycle after state entry, with sb_adr = {BUS_ADDR74, offset}, sb_rw and sb_dat_w.
  - All bus outputs are held stable until the cycle in which sb_ack=1.
  - Read data is captured from sb_dat_r in that same ack cycle.
  - sb_stb=0 on the next cycle; at least one idle cycle separates strobes.
  - sb_ack while sb_stb=0 is ignored.
- Configuration sequence, one bus write each:
  - CFG0: SPICR0 <- CR0_VAL.
  - CFG2: SPICR2 <- CR2_VAL.
  - CFGB: SPIBR <- BR_VAL.
  - CFG1: SPICR1 <- CR1_VAL (enable written last).
  - Then IDLE.
- Transfer states:
  - IDLE: busy=0, tx_ready=1. On accept, latch the byte and last flag -> CS_ON.
  - CS_ON: write SPICSR <- CS_MASK -> POLL_T.
  - POLL_T: read SPISR (0xC). Bit4 TRDY=1 -> WR_TX; otherwise repeat POLL_T.
  - WR_TX: write SPITXDR (0xD) <- latched byte -> POLL_R.
  - POLL_R: read SPISR until bit3 RRDY=1 -> RD_RX.
  - RD_RX: read SPIRXDR (0xE) into rx_data -> RX_OUT.
  - RX_OUT: rx_valid=1 until rx_ready.
    - On handshake with last=1 -> CS_OFF.
    - Otherwise -> IN_FRAME.
  - IN_FRAME: tx_ready=1, CS stays asserted. On accept -> POLL_T (no SPICSR write).
  - CS_OFF: write SPICSR <- 8'h00 -> IDLE.
- Ordering and boundary rules:
  - tx_ready is 0 in every state except IDLE and IN_FRAME, so at most one byte is in flight.
  - rx_data updates only in the RD_RX ack cycle.
  - A frame of one byte with tx_last=1 performs CS_ON and CS_OFF around the single byte.
  - Polling is unbounded unless the optional feature is compiled in.
  - Status bits other than TRDY and RRDY are ignored.

Optional Feature:
- Macro: SB_SPI_HOST_ACK_TIMEOUT_EN.
- Defined:
  - A counter runs while sb_stb=1 and is cleared on ack.
  - When it reaches ACK_TIMEOUT, sb_stb drops, err sets (cleared only by reset), and the FSM goes to CS_OFF. If the timeout occurs during configuration, the FSM goes to IDLE instead.
  - Any pending rx_valid is dropped.
- Undefined: no counter; err is tied to 0; a bus cycle waits for ack indefinitely.

Decomposition:
- Package sb_spi_pkg holds:
  - register offset constants: SPICR0..2, SPIBR, SPISR, SPITXDR, SPIRXDR, SPICSR;
  - SPISR bit indices TRDY=4 and RRDY=3;
  - the FSM state enum typedef.
- One sub-module, sb_bus_xfer: single-transaction strobe/ack engine with start/done, addr, wdata, rdata and the optional watchdog. The top-level FSM sequences it.

Test Plan:
- Reset, bus responder acks after 2 cycles -> writes in order: 0x08<-00, 0x0A<-C0, 0x0B<-05, 0x09<-80; then busy=0, tx_ready=1.
- Send 0xA5 with last=1; SPISR reads 0x00 twice then 0x10; RX path returns 0x08 then 0x3C -> bus sequence:
  - 0x0F<-01;
  - SPISR read ×3;
  - 0x0D<-A5;
  - SPISR reads until 0x08;
  - 0x0E read gives rx_data=0x3C;
  - 0x0F<-00.
- Three-byte frame 11,22,33 (last on 33) -> exactly one CS_MASK write before 0x11 and one 0x00 write after 0x33; tx_ready=0 between bytes until each rx handshake.
- rx_ready held 0 for 10 cycles -> rx_valid and rx_data stay stable, no bus activity, tx_ready=0.
- rst_n low for 1 cycle while sb_stb=1 in POLL_R -> sb_stb=0 next cycle, configuration restarts from 0x08.
- With SB_SPI_HOST_ACK_TIMEOUT_EN and ACK_TIMEOUT=64, withhold ack on the WR_TX write -> sb_stb falls after 64 cycles, err=1, CS_OFF write to 0x0F issued, IDLE reached.

Source files
------------

// File: rtl/sb_spi_pkg.sv
// Shared definitions for the SB_SPI system-bus host.
// Register offsets, status bit positions and the sequencer state type.
package sb_spi_pkg;

    localparam logic [3:0] SPICR0  = 4'h8;
    localparam logic [3:0] SPICR1  = 4'h9;
    localparam logic [3:0] SPICR2  = 4'hA;
    localparam logic [3:0] SPIBR   = 4'hB;
    localparam logic [3:0] SPISR   = 4'hC;
    localparam logic [3:0] SPITXDR = 4'hD;
    localparam logic [3:0] SPIRXDR = 4'hE;
    localparam logic [3:0] SPICSR  = 4'hF;

    localparam int TRDY = 4;
    localparam int RRDY = 3;

    typedef enum logic [3:0] {
        CFG0,
        CFG2,
        CFGB,
        CFG1,
        IDLE,
        CS_ON,
        POLL_T,
        WR_TX,
        POLL_R,
        RD_RX,
        RX_OUT,
        IN_FRAME,
        CS_OFF
    } state_e;

endpackage

// File: rtl/sb_bus_xfer.sv
// Single strobe/ack transaction engine towards the SB_SPI register port.
// SB_SPI_HOST_ACK_TIMEOUT_EN adds an ack watchdog that aborts the strobe.
module sb_bus_xfer #(
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic       timeout,
    output logic       sb_stb,
    output logic       sb_rw,
    output logic [7:0] sb_adr,
    output logic [7:0] sb_dat_w,
    input  logic [7:0] sb_dat_r,
    input  logic       sb_ack
);

    // A new strobe is only launched from stb=0, which guarantees an idle gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_stb   <= 1'b0;
            sb_rw    <= 1'b0;
            sb_adr   <= 8'h00;
            sb_dat_w <= 8'h00;
        end else if (sb_stb) begin
            if (sb_ack || timeout) begin
                sb_stb <= 1'b0;
            end
        end else if (start) begin
            sb_stb   <= 1'b1;
            sb_rw    <= we;
            sb_adr   <= addr;
            sb_dat_w <= wdata;
        end
    end

    assign done  = sb_stb && sb_ack;
    assign rdata = sb_dat_r;

`ifdef SB_SPI_HOST_ACK_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !sb_stb || sb_ack) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires in the strobe's ACK_TIMEOUT-th cycle, so stb is high that long.
    assign timeout = sb_stb && !sb_ack && (cnt == CW'(ACK_TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = |ACK_TIMEOUT;
    assign timeout    = 1'b0;
`endif

endmodule

// File: rtl/sb_spi_host.sv
// SPI master sequencer driving the iCE40 SB_SPI hard block over its system bus.
// SB_SPI_HOST_ACK_TIMEOUT_EN enables the bus-ack watchdog and the err flag.
module sb_spi_host
    import sb_spi_pkg::*;
#(
    parameter logic [3:0]  BUS_ADDR74  = 4'b0000,
    parameter logic [7:0]  CR0_VAL     = 8'h00,
    parameter logic [7:0]  CR1_VAL     = 8'h80,
    parameter logic [7:0]  CR2_VAL     = 8'hC0,
    parameter logic [7:0]  BR_VAL      = 8'h05,
    parameter logic [7:0]  CS_MASK     = 8'h01,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       err,
    output logic       sb_stb,
    output logic       sb_rw,
    output logic [7:0] sb_adr,
    output logic [7:0] sb_dat_w,
    input  logic [7:0] sb_dat_r,
    input  logic       sb_ack
);

    state_e     state_q, state_d;
    logic       start, we, done, timeout;
    logic [3:0] off;
    logic [7:0] wdata, rdata;
    logic [7:0] tx_byte;
    logic       last_q;

    sb_bus_xfer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_xfer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .we      (we),
        .addr    ({BUS_ADDR74, off}),
        .wdata   (wdata),
        .rdata   (rdata),
        .done    (done),
        .timeout (timeout),
        .sb_stb  (sb_stb),
        .sb_rw   (sb_rw),
        .sb_adr  (sb_adr),
        .sb_dat_w(sb_dat_w),
        .sb_dat_r(sb_dat_r),
        .sb_ack  (sb_ack)
    );

    assign tx_ready = (state_q == IDLE) || (state_q == IN_FRAME);
    assign rx_valid = (state_q == RX_OUT);
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        we      = 1'b0;
        off     = 4'h0;
        wdata   = 8'h00;
        unique case (state_q)
            CFG0: begin
                start = 1'b1; we = 1'b1; off = SPICR0; wdata = CR0_VAL;
                if (done) state_d = CFG2;
            end
            CFG2: begin
                start = 1'b1; we = 1'b1; off = SPICR2; wdata = CR2_VAL;
                if (done) state_d = CFGB;
            end
            CFGB: begin
                start = 1'b1; we = 1'b1; off = SPIBR; wdata = BR_VAL;
                if (done) state_d = CFG1;
            end
            CFG1: begin
                start = 1'b1; we = 1'b1; off = SPICR1; wdata = CR1_VAL;
                if (done) state_d = IDLE;
            end
            IDLE: begin
                if (tx_valid) state_d = CS_ON;
            end
            CS_ON: begin
                start = 1'b1; we = 1'b1; off = SPICSR; wdata = CS_MASK;
                if (done) state_d = POLL_T;
            end
            POLL_T: begin
                start = 1'b1; off = SPISR;
                if (done && rdata[TRDY]) state_d = WR_TX;
            end
            WR_TX: begin
                start = 1'b1; we = 1'b1; off = SPITXDR; wdata = tx_byte;
                if (done) state_d = POLL_R;
            end
            POLL_R: begin
                start = 1'b1; off = SPISR;
                if (done && rdata[RRDY]) state_d = RD_RX;
            end
            RD_RX: begin
                start = 1'b1; off = SPIRXDR;
                if (done) state_d = RX_OUT;
            end
            RX_OUT: begin
                if (rx_ready) state_d = last_q ? CS_OFF : IN_FRAME;
            end
            IN_FRAME: begin
                if (tx_valid) state_d = POLL_T;
            end
            CS_OFF: begin
                start = 1'b1; we = 1'b1; off = SPICSR; wdata = 8'h00;
                if (done) state_d = IDLE;
            end
            default: state_d = CFG0;
        endcase
        // Abort: release CS unless no frame is open (config or CS release itself).
        if (timeout) begin
            if (state_q inside {CFG0, CFG2, CFGB, CFG1, CS_OFF}) begin
                state_d = IDLE;
            end else begin
                state_d = CS_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CFG0;
            tx_byte <= 8'h00;
            last_q  <= 1'b0;
            rx_data <= 8'h00;
        end else begin
            state_q <= state_d;
            if (tx_valid && tx_ready) begin
                tx_byte <= tx_data;
                last_q  <= tx_last;
            end
            if (state_q == RD_RX && done) begin
                rx_data <= rdata;
            end
        end
    end

`ifdef SB_SPI_HOST_ACK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sb_spi_host.sv
// Directed bench for sb_spi_host with a logging SB_SPI bus responder.
// Covers config order, framing, rx back-pressure, reset abort and the watchdog.
module tb_sb_spi_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       busy;
    logic       err;
    logic       sb_stb;
    logic       sb_rw;
    logic [7:0] sb_adr;
    logic [7:0] sb_dat_w;
    logic [7:0] sb_dat_r = 8'h00;
    logic       sb_ack = 1'b0;

    always #5 clk = ~clk;

    sb_spi_host dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_last (tx_last),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .busy    (busy),
        .err     (err),
        .sb_stb  (sb_stb),
        .sb_rw   (sb_rw),
        .sb_adr  (sb_adr),
        .sb_dat_w(sb_dat_w),
        .sb_dat_r(sb_dat_r),
        .sb_ack  (sb_ack)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [16:0] ent(input logic rw, input logic [7:0] a,
                                        input logic [7:0] d);
        return {rw, a, d};
    endfunction

    logic [16:0] log_q[$];
    logic [16:0] exq[$];
    logic [7:0]  sr_q[$];
    logic [7:0]  rx_q[$];
    int          hold_at = 1000;
    logic [7:0]  hold_adr = 8'h00;
    int          wait_cnt = 0;
    logic [7:0]  resp;

    // Responder: ack in the 2nd cycle of a strobe unless told to stall it.
    always @(negedge clk) begin
        if (sb_ack) begin
            sb_ack = 1'b0;
            wait_cnt = 0;
        end else if (!sb_stb) begin
            wait_cnt = 0;
        end else if (!(log_q.size() == hold_at && sb_adr == hold_adr)) begin
            wait_cnt++;
            if (wait_cnt >= 2) begin
                resp = 8'h00;
                if (!sb_rw && sb_adr == 8'h0C) begin
                    resp = 8'h18;
                    if (sr_q.size() != 0) resp = sr_q.pop_front();
                end
                if (!sb_rw && sb_adr == 8'h0E && rx_q.size() != 0)
                    resp = rx_q.pop_front();
                sb_dat_r = resp;
                sb_ack = 1'b1;
                log_q.push_back(ent(sb_rw, sb_adr, sb_rw ? sb_dat_w : resp));
            end
        end
    end

    logic        prev_stb = 1'b0;
    logic [16:0] prev_bus = '0;
    int          unstable = 0;

    always @(negedge clk) begin
        if (sb_stb && prev_stb && {sb_rw, sb_adr, sb_dat_w} != prev_bus)
            unstable++;
        prev_stb = sb_stb;
        prev_bus = {sb_rw, sb_adr, sb_dat_w};
    end

    task automatic check_log(input string tag);
        check({tag, "_len"}, log_q.size(), exq.size());
        foreach (exq[i])
            check($sformatf("%s_%0d", tag, i),
                  (i < log_q.size()) ? log_q[i] : 17'h1ffff, exq[i]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", tx_ready, 1);
        tx_data = d;
        tx_last = l;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        check("ready_after_accept", tx_ready, 0);
    endtask

    task automatic wait_rx();
        int n = 0;
        while (!rx_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rx_valid_seen", rx_valid, 1);
    endtask

    task automatic recv(input logic [7:0] exp);
        wait_rx();
        check("rx_data", rx_data, exp);
        check("tx_ready_while_rx", tx_ready, 0);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic exp_cfg();
        exq.delete();
        exq.push_back(ent(1, 8'h08, 8'h00));
        exq.push_back(ent(1, 8'h0A, 8'hC0));
        exq.push_back(ent(1, 8'h0B, 8'h05));
        exq.push_back(ent(1, 8'h09, 8'h80));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_stb", sb_stb, 0);
        check("rst_adr", sb_adr, 0);
        check("rst_busy", busy, 1);
        check("rst_err", err, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;

        wait_idle("cfg_idle");
        exp_cfg();
        check_log("cfg");
        check("idle_tx_ready", tx_ready, 1);

        // Single-byte frame with slow TRDY/RRDY.
        log_q.delete();
        sr_q = '{8'h00, 8'h00, 8'h10, 8'h08};
        rx_q = '{8'h3C};
        send(8'hA5, 1'b1);
        recv(8'h3C);
        wait_idle("one_idle");
        exq.delete();
        exq.push_back(ent(1, 8'h0F, 8'h01));
        exq.push_back(ent(0, 8'h0C, 8'h00));
        exq.push_back(ent(0, 8'h0C, 8'h00));
        exq.push_back(ent(0, 8'h0C, 8'h10));
        exq.push_back(ent(1, 8'h0D, 8'hA5));
        exq.push_back(ent(0, 8'h0C, 8'h08));
        exq.push_back(ent(0, 8'h0E, 8'h3C));
        exq.push_back(ent(1, 8'h0F, 8'h00));
        check_log("one");
        check("one_rx_data_held", rx_data, 8'h3C);

        // Three-byte frame with back-pressure on the first byte.
        log_q.delete();
        rx_q = '{8'hC1, 8'hC2, 8'hC3};
        send(8'h11, 1'b0);
        wait_rx();
        repeat (10) @(negedge clk);
        check("bp_rx_valid", rx_valid, 1);
        check("bp_rx_data", rx_data, 8'hC1);
        check("bp_bus_quiet", log_q.size(), 5);
        check("bp_stb", sb_stb, 0);
        check("bp_tx_ready", tx_ready, 0);
        recv(8'hC1);
        @(negedge clk);
        check("in_frame_ready", tx_ready, 1);
        check("in_frame_busy", busy, 1);
        send(8'h22, 1'b0);
        recv(8'hC2);
        send(8'h33, 1'b1);
        recv(8'hC3);
        wait_idle("three_idle");
        exq.delete();
        exq.push_back(ent(1, 8'h0F, 8'h01));
        exq.push_back(ent(0, 8'h0C, 8'h18));
        exq.push_back(ent(1, 8'h0D, 8'h11));
        exq.push_back(ent(0, 8'h0C, 8'h18));
        exq.push_back(ent(0, 8'h0E, 8'hC1));
        exq.push_back(ent(0, 8'h0C, 8'h18));
        exq.push_back(ent(1, 8'h0D, 8'h22));
        exq.push_back(ent(0, 8'h0C, 8'h18));
        exq.push_back(ent(0, 8'h0E, 8'hC2));
        exq.push_back(ent(0, 8'h0C, 8'h18));
        exq.push_back(ent(1, 8'h0D, 8'h33));
        exq.push_back(ent(0, 8'h0C, 8'h18));
        exq.push_back(ent(0, 8'h0E, 8'hC3));
        exq.push_back(ent(1, 8'h0F, 8'h00));
        check_log("three");

        // Reset while the RRDY poll strobe is stalled.
        log_q.delete();
        sr_q = '{8'h10};
        hold_at = 3;
        hold_adr = 8'h0C;
        send(8'h5A, 1'b1);
        n = 0;
        while (!(sb_stb && sb_adr == 8'h0C && log_q.size() == 3) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("pollr_stb", sb_stb, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_stb", sb_stb, 0);
        check("rst_mid_busy", busy, 1);
        log_q.delete();
        sr_q.delete();
        rx_q.delete();
        hold_at = 1000;
        rst_n = 1'b1;
        wait_idle("recfg_idle");
        exp_cfg();
        check_log("recfg");

`ifdef SB_SPI_HOST_ACK_TIMEOUT_EN
        // Ack withheld on the TX write: watchdog aborts to CS release.
        log_q.delete();
        hold_at = 2;
        hold_adr = 8'h0D;
        send(8'h77, 1'b1);
        n = 0;
        while (!(sb_stb && sb_adr == 8'h0D) && n < 300) begin
            @(negedge clk);
            n++;
        end
        n = 1;
        @(negedge clk);
        while (sb_stb && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("to_stb_cycles", n, 64);
        check("to_err", err, 1);
        wait_idle("to_idle");
        hold_at = 1000;
        exq.delete();
        exq.push_back(ent(1, 8'h0F, 8'h01));
        exq.push_back(ent(0, 8'h0C, 8'h18));
        exq.push_back(ent(1, 8'h0F, 8'h00));
        check_log("to");
        check("to_rx_valid", rx_valid, 0);
        check("to_err_sticky", err, 1);
`else
        check("err_tied", err, 0);
`endif

        check("bus_stable", unstable, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
